uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receive path: serial-in/parallel-out deserialiser, the receive-side counterpart of the
//   transmit shift register. Synchronises the async rx line, detects start bits, samples each
//   bit at mid-bit using an OVERSAMPLE x baud tick, checks optional parity and the stop bit,
//   and presents the received byte with a one-cycle valid strobe to the host side.
// PARAMETERS
//   DATA_BITS   8    data bits per frame (5..8), LSB first on the line
//   OVERSAMPLE  16   sample_tick pulses per bit period (even, >= 4)
//   PARITY_EN   0    1 = parity bit follows data bits
//   PARITY_ODD  0    1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
// PORTS
//   clk          input   1          system clock, all logic on posedge
//   reset        input   1          asynchronous, active-high reset
//   rx_serial    input   1          async serial line, idle high
//   sample_tick  input   1          1-clk enable, OVERSAMPLE per bit period
//   rx_data      output  DATA_BITS  last received word, LSB = first data bit
//   rx_valid     output  1          1-clk pulse: rx_data/flags updated
//   parity_err   output  1          parity mismatch on last frame (0 if PARITY_EN = 0)
//   frame_err    output  1          stop bit sampled low on last frame
//   busy         output  1          high whenever FSM is not IDLE
// BEHAVIOUR
// - Reset (async): state IDLE, sync flops = 1, rx_data = 0, rx_valid/parity_err/frame_err/busy = 0,
//   tick counter = 0, bit counter = 0, armed = 1.
// - rx_serial passes a 2-flop synchroniser (rx_s); all decisions use rx_s. Only clock cycles
//   with sample_tick = 1 advance counters/FSM; other cycles hold state.
// - Tick counter width $clog2(OVERSAMPLE); bit counter width $clog2(DATA_BITS+1).
// - IDLE: armed set on a tick with rx_s = 1. Tick with rx_s = 0 and armed -> START, cnt = 0.
// - START: cnt increments per tick; at cnt = OVERSAMPLE/2-1 (mid start bit) sample rx_s:
//   1 -> false start, back to IDLE (no rx_valid, flags unchanged); 0 -> DATA, cnt = 0, bit = 0.
// - DATA: at cnt = OVERSAMPLE-1 sample rx_s, shift right into sr (sr <= {rx_s, sr[DATA_BITS-1:1]}),
//   cnt = 0, bit++. After DATA_BITS-th sample -> PARITY if PARITY_EN else STOP.
// - PARITY: at cnt = OVERSAMPLE-1 capture parity bit; perr = ^{sr, p} ^ PARITY_ODD != 0 -> STOP.
// - STOP: at cnt = OVERSAMPLE-1 sample stop bit -> IDLE. On the next clk edge: rx_data <= sr,
//   parity_err <= perr, frame_err <= ~stop, rx_valid = 1 for exactly one clk.
//   Latency: rx_valid high the clk cycle after the stop-sample tick.
// - Return to IDLE at mid stop bit so a back-to-back start bit is never missed.
// - Stop sampled low (framing error / break): armed cleared; no new start accepted until
//   rx_s seen high on a tick, so a held-low line yields exactly one frame_err frame.
// - rx_data and error flags hold their values until the next rx_valid; no host handshake,
//   an unread word is overwritten (host must consume on rx_valid).
// - busy = (state != IDLE), combinational from state register.
// - Reset mid-frame: abort immediately, outputs to reset values, partial data discarded.
// - sample_tick held continuously high is legal (OVERSAMPLE clks per bit).
// TESTING (OVERSAMPLE=16, DATA_BITS=8, sample_tick every 4 clks unless noted)
// 1. Send 0xA5, 8N1, stop=1 -> one rx_valid pulse, rx_data=0xA5, frame_err=0, parity_err=0.
// 2. Drive rx low 5 ticks then high -> START aborts at tick 7, no rx_valid, busy back to 0.
// 3. Send 0x3C with stop=0 -> rx_valid, rx_data=0x3C, frame_err=1; hold line low 40 bit-times
//    -> no further rx_valid until line high then a fresh frame.
// 4. PARITY_EN=1 even: 0x3C parity=0 -> parity_err=0; 0x3C parity=1 -> parity_err=1.
// 5. 0x55 then 0xAA back-to-back (next start right after stop bit) -> two rx_valid pulses,
//    data 0x55 then 0xAA, no errors.
// 6. Assert reset during bit 3 of a frame -> all outputs 0 next cycle; after release
//    send 0x0F -> rx_data=0x0F, rx_valid once, no errors.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: synchronised, oversampled start/data/parity/stop deserialiser.
// Presents each received word with a one-clock valid strobe and error flags.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bitc, bitc_n;
  logic [DATA_BITS-1:0] sr, sr_n;
  logic                 perr, perr_n;
  logic                 armed, armed_n;
  logic                 load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_serial;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      bitc  <= '0;
      sr    <= '0;
      perr  <= 1'b0;
      armed <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitc  <= bitc_n;
      sr    <= sr_n;
      perr  <= perr_n;
      armed <= armed_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bitc_n  = bitc;
    sr_n    = sr;
    perr_n  = perr;
    armed_n = armed;
    load    = 1'b0;
    if (sample_tick) begin
      unique case (state)
        IDLE: begin
          if (rx_s) begin
            armed_n = 1'b1;
          end else if (armed) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt_n   = '0;
            bitc_n  = '0;
            perr_n  = 1'b0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            sr_n   = {rx_s, sr[DATA_BITS-1:1]};
            cnt_n  = '0;
            bitc_n = bitc + BW'(1);
            if (bitc == BLAST)
              state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            perr_n  = (^{sr, rx_s}) ^ (PARITY_ODD != 0);
            cnt_n   = '0;
            state_n = STOP;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            // Leave at mid stop bit; a low stop disarms until the line idles
            load    = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
            if (!rx_s) armed_n = 1'b0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= load;
      if (load) begin
        rx_data    <= sr;
        parity_err <= perr;
        frame_err  <= ~rx_s;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 8N1 and 8E1 instances, vector table plus corner sequences.
// Tick every 4 clocks, 16 ticks per bit, so one bit is 64 clocks.
module tb_uart_rx;

  localparam int BITCLK = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] div = 2'd0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;

  logic [7:0] d0, d1;
  logic       v0, v1, pe0, pe1, fe0, fe1, b0, b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  logic [7:0] q0[$];
  logic busy_seen = 1'b0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .rx_serial(rx0), .sample_tick(tick),
    .rx_data(d0), .rx_valid(v0), .parity_err(pe0), .frame_err(fe0), .busy(b0)
  );

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .rx_serial(rx1), .sample_tick(tick),
    .rx_data(d1), .rx_valid(v1), .parity_err(pe1), .frame_err(fe1), .busy(b1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div  <= div + 2'd1;
    tick <= (div == 2'd3);
  end

  always @(negedge clk) begin
    if (v0) begin
      cnt0 = cnt0 + 1;
      q0.push_back(d0);
    end
    if (v1) cnt1 = cnt1 + 1;
    if (b0) busy_seen = 1'b1;
  end

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       p;
    logic       stop;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bits(input int n);
    repeat (n * BITCLK) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic send(input int sel, input logic [7:0] d, input logic p,
                      input logic stop, input logic keep);
    drive(sel, 1'b0);
    bits(1);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      bits(1);
    end
    if (sel == 1) begin
      drive(sel, p);
      bits(1);
    end
    drive(sel, stop);
    bits(1);
    if (!keep) drive(sel, 1'b1);
  endtask

  initial begin
    int c0, c1, qs;
    logic fe_before;

    vt[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vt[2] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[3] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[4] = '{0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vt[5] = '{1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vt[6] = '{1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vt[7] = '{1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[8] = '{1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[9] = '{1, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};

    repeat (5) @(negedge clk);
    check("reset_valid", 32'(v0), 32'h0);
    check("reset_data", 32'(d0), 32'h0);
    check("reset_perr", 32'(pe0), 32'h0);
    check("reset_ferr", 32'(fe0), 32'h0);
    check("reset_busy", 32'(b0), 32'h0);
    reset = 1'b0;
    bits(2);

    for (int i = 0; i < 10; i++) begin
      c0 = cnt0;
      c1 = cnt1;
      send(vt[i].sel, vt[i].d, vt[i].p, vt[i].stop, 1'b0);
      bits(2);
      if (vt[i].sel == 0) begin
        check($sformatf("v%0d_count", i), 32'(cnt0 - c0), 32'd1);
        check($sformatf("v%0d_data", i), 32'(d0), 32'(vt[i].ed));
        check($sformatf("v%0d_perr", i), 32'(pe0), 32'(vt[i].epe));
        check($sformatf("v%0d_ferr", i), 32'(fe0), 32'(vt[i].efe));
      end else begin
        check($sformatf("v%0d_count", i), 32'(cnt1 - c1), 32'd1);
        check($sformatf("v%0d_data", i), 32'(d1), 32'(vt[i].ed));
        check($sformatf("v%0d_perr", i), 32'(pe1), 32'(vt[i].epe));
        check($sformatf("v%0d_ferr", i), 32'(fe1), 32'(vt[i].efe));
      end
    end

    // false start: 5 ticks low, then high
    c0 = cnt0;
    fe_before = fe0;
    busy_seen = 1'b0;
    rx0 = 1'b0;
    repeat (20) @(negedge clk);
    rx0 = 1'b1;
    bits(2);
    check("false_busy_seen", 32'(busy_seen), 32'h1);
    check("false_busy_idle", 32'(b0), 32'h0);
    check("false_no_valid", 32'(cnt0 - c0), 32'h0);
    check("false_flags_hold", 32'(fe0), 32'(fe_before));

    // break: stop low and line held low 40 bit-times
    c0 = cnt0;
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    bits(40);
    check("break_one_valid", 32'(cnt0 - c0), 32'd1);
    check("break_data", 32'(d0), 32'h3C);
    check("break_ferr", 32'(fe0), 32'h1);
    rx0 = 1'b1;
    bits(2);
    check("break_after_high", 32'(cnt0 - c0), 32'd1);
    send(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    bits(2);
    check("break_fresh_count", 32'(cnt0 - c0), 32'd2);
    check("break_fresh_data", 32'(d0), 32'hA5);
    check("break_fresh_ferr", 32'(fe0), 32'h0);

    // back-to-back frames
    c0 = cnt0;
    qs = q0.size();
    send(0, 8'h55, 1'b0, 1'b1, 1'b0);
    send(0, 8'hAA, 1'b0, 1'b1, 1'b0);
    bits(2);
    check("b2b_count", 32'(cnt0 - c0), 32'd2);
    if (q0.size() >= qs + 2) begin
      check("b2b_first", 32'(q0[qs]), 32'h55);
      check("b2b_second", 32'(q0[qs+1]), 32'hAA);
    end else begin
      check("b2b_queue", 32'(q0.size() - qs), 32'd2);
    end
    check("b2b_perr", 32'(pe0), 32'h0);
    check("b2b_ferr", 32'(fe0), 32'h0);

    // reset in the middle of bit 3
    rx0 = 1'b0;
    bits(1);
    rx0 = 1'b1;
    bits(1);
    rx0 = 1'b0;
    bits(1);
    rx0 = 1'b1;
    bits(1);
    rx0 = 1'b0;
    repeat (BITCLK / 2) @(negedge clk);
    check("mid_busy_before", 32'(b0), 32'h1);
    reset = 1'b1;
    rx0 = 1'b1;
    #1;
    check("mid_rst_valid", 32'(v0), 32'h0);
    check("mid_rst_data", 32'(d0), 32'h0);
    check("mid_rst_ferr", 32'(fe0), 32'h0);
    check("mid_rst_busy", 32'(b0), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bits(2);
    c0 = cnt0;
    send(0, 8'h0F, 1'b0, 1'b1, 1'b0);
    bits(2);
    check("post_rst_count", 32'(cnt0 - c0), 32'd1);
    check("post_rst_data", 32'(d0), 32'h0F);
    check("post_rst_perr", 32'(pe0), 32'h0);
    check("post_rst_ferr", 32'(fe0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
